id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core: holds decoded operands/control,
// forwards from EX/MEM and MEM/WB into the ALU, and raises a one-cycle load-use stall.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_dest_addr,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [3:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_dest,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_dest,
    input  logic [DATA_W-1:0] memwb_result,
    input  logic              flush,
    output logic              stall,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    logic              valid_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [REG_AW-1:0] rs_addr_q;
    logic [REG_AW-1:0] rt_addr_q;
    logic [REG_AW-1:0] dest_q;
    logic [DATA_W-1:0] imm_q;
    logic [4:0]        shamt_q;
    logic [3:0]        alu_op_q;
    logic              alu_src_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              mem_to_reg_q;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // A load in this stage cannot supply its data to the instruction now in decode.
    always_comb begin
        stall = valid_q & mem_read_q & (dest_q != '0) & id_valid &
                ((dest_q == id_rs_addr) | (dest_q == id_rt_addr));
    end

    always_ff @(posedge clk) begin
        if (reset || flush || stall) begin
            valid_q      <= 1'b0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            dest_q       <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            alu_op_q     <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= id_valid;
            rs_data_q    <= id_rs_data;
            rt_data_q    <= id_rt_data;
            rs_addr_q    <= id_rs_addr;
            rt_addr_q    <= id_rt_addr;
            dest_q       <= id_dest_addr;
            imm_q        <= id_imm;
            shamt_q      <= id_shamt;
            alu_op_q     <= id_alu_op;
            alu_src_q    <= id_alu_src;
            reg_write_q  <= id_reg_write;
            mem_read_q   <= id_mem_read;
            mem_write_q  <= id_mem_write;
            mem_to_reg_q <= id_mem_to_reg;
        end
    end

    // The younger producer (EX/MEM) wins; $0 always keeps its registered value.
    always_comb begin
        fwd_rs = rs_data_q;
        if (exmem_reg_write && (exmem_dest != '0) && (exmem_dest == rs_addr_q)) begin
            fwd_rs = exmem_result;
        end else if (memwb_reg_write && (memwb_dest != '0) && (memwb_dest == rs_addr_q)) begin
            fwd_rs = memwb_result;
        end

        fwd_rt = rt_data_q;
        if (exmem_reg_write && (exmem_dest != '0) && (exmem_dest == rt_addr_q)) begin
            fwd_rt = exmem_result;
        end else if (memwb_reg_write && (memwb_dest != '0) && (memwb_dest == rt_addr_q)) begin
            fwd_rt = memwb_result;
        end
    end

    assign alu_op        = alu_op_q;
    assign alu_a         = fwd_rs;
    assign alu_b         = alu_src_q ? imm_q : fwd_rt;
    assign alu_shamt     = shamt_q;
    assign ex_store_data = fwd_rt;
    assign ex_dest       = dest_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q  & valid_q;
    assign ex_mem_read   = mem_read_q   & valid_q;
    assign ex_mem_write  = mem_write_q  & valid_q;
    assign ex_mem_to_reg = mem_to_reg_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an instruction-level model.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs_addr, id_rt_addr, id_dest_addr, id_shamt;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write, flush;
    logic [4:0]  exmem_dest, memwb_dest;
    logic [31:0] exmem_result, memwb_result;
    logic        stall;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  alu_shamt, ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int compared = 0;
    int mismatched = 0;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_dest_addr(id_dest_addr),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
        .flush(flush), .stall(stall), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_shamt(alu_shamt), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The model tracks which instruction occupies the stage, as a whole record.
    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, dest, shamt;
        logic [3:0]  op;
        logic        src, rw, mr, mw, m2r;
    } instr_t;

    instr_t stage_m;
    bit     model_ready = 0;
    bit     hazard_now;

    function automatic logic [31:0] forwarded(input logic [4:0] addr, input logic [31:0] own);
        if (addr == 5'd0) return own;
        if (exmem_reg_write && exmem_dest == addr) return exmem_result;
        if (memwb_reg_write && memwb_dest == addr) return memwb_result;
        return own;
    endfunction

    function automatic bit load_use();
        return stage_m.valid && stage_m.mr && stage_m.dest != 5'd0 && id_valid &&
               (stage_m.dest == id_rs_addr || stage_m.dest == id_rt_addr);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    always @(posedge clk) begin
        hazard_now = load_use();
        if (reset || flush || hazard_now) begin
            stage_m = '0;
        end else begin
            stage_m.valid   = id_valid;
            stage_m.rs_data = id_rs_data;
            stage_m.rt_data = id_rt_data;
            stage_m.imm     = id_imm;
            stage_m.rs      = id_rs_addr;
            stage_m.rt      = id_rt_addr;
            stage_m.dest    = id_dest_addr;
            stage_m.shamt   = id_shamt;
            stage_m.op      = id_alu_op;
            stage_m.src     = id_alu_src;
            stage_m.rw      = id_reg_write;
            stage_m.mr      = id_mem_read;
            stage_m.mw      = id_mem_write;
            stage_m.m2r     = id_mem_to_reg;
        end
        if (reset) model_ready = 1;
    end

    always @(negedge clk) begin
        #1;
        if (model_ready) begin
            checkOutput("stall", {31'd0, stall}, {31'd0, load_use()});
            checkOutput("ex_valid", {31'd0, ex_valid}, {31'd0, stage_m.valid});
            checkOutput("alu_op", {28'd0, alu_op}, {28'd0, stage_m.op});
            checkOutput("alu_a", alu_a, forwarded(stage_m.rs, stage_m.rs_data));
            checkOutput("alu_b", alu_b, stage_m.src ? stage_m.imm : forwarded(stage_m.rt, stage_m.rt_data));
            checkOutput("alu_shamt", {27'd0, alu_shamt}, {27'd0, stage_m.shamt});
            checkOutput("ex_store_data", ex_store_data, forwarded(stage_m.rt, stage_m.rt_data));
            checkOutput("ex_dest", {27'd0, ex_dest}, {27'd0, stage_m.dest});
            checkOutput("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, stage_m.rw & stage_m.valid});
            checkOutput("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, stage_m.mr & stage_m.valid});
            checkOutput("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, stage_m.mw & stage_m.valid});
            checkOutput("ex_mem_to_reg", {31'd0, ex_mem_to_reg}, {31'd0, stage_m.m2r & stage_m.valid});
        end
    end

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] dest, input logic [31:0] rsd, input logic [31:0] rtd,
                                 input logic [31:0] imm, input logic [4:0] sh, input logic [3:0] op,
                                 input logic src, input logic rw, input logic mr, input logic mw,
                                 input logic m2r);
        id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_dest_addr = dest;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh; id_alu_op = op;
        id_alu_src = src; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic applyForward(input logic ew, input logic [4:0] ed, input logic [31:0] er,
                                input logic mw, input logic [4:0] md, input logic [31:0] mr);
        exmem_reg_write = ew; exmem_dest = ed; exmem_result = er;
        memwb_reg_write = mw; memwb_dest = md; memwb_result = mr;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        applyForward(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 5'd3, 5'd4, 5'd7, 32'h1234, 32'h5678, 32'h9, 5'd2, 4'd3, 0, 1, 1, 1, 1);
        step();
        step();
        #1;
        $display("[TB] reset state");
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rst_alu_a", alu_a, 32'd0);
        checkOutput("rst_mem_read", {31'd0, ex_mem_read}, 32'd0);

        // Plain ADD, captured on the first edge after reset release
        reset = 1'b0;
        applyStimulus(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 5'd0, 4'b0011, 0, 1, 0, 0, 0);
        step();
        #1;
        checkOutput("add_alu_a", alu_a, 32'd5);
        checkOutput("add_alu_b", alu_b, 32'd7);
        checkOutput("add_alu_op", {28'd0, alu_op}, 32'd3);
        checkOutput("add_reg_write", {31'd0, ex_reg_write}, 32'd1);

        // Forwarding priority with rs=$8, rt=$9
        applyStimulus(1, 5'd8, 5'd9, 5'd10, 32'hAAAA, 32'hBBBB, 32'd0, 5'd0, 4'b0011, 0, 1, 0, 0, 0);
        step();
        applyForward(1, 5'd8, 32'h11, 1, 5'd8, 32'h22);
        #1;
        checkOutput("fwd_prio_a", alu_a, 32'h11);
        checkOutput("fwd_none_b", alu_b, 32'hBBBB);
        applyForward(1, 5'd8, 32'h11, 1, 5'd9, 32'h33);
        #1;
        checkOutput("fwd_ex_a", alu_a, 32'h11);
        checkOutput("fwd_wb_b", alu_b, 32'h33);
        applyStimulus(1, 5'd0, 5'd0, 5'd10, 32'h1234, 32'h5678, 32'd0, 5'd0, 4'b0011, 0, 1, 0, 0, 0);
        applyForward(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
        step();
        #1;
        checkOutput("zero_a", alu_a, 32'h1234);
        checkOutput("zero_b", alu_b, 32'h5678);

        // Load-use: LW $4 then ADD using $4
        applyForward(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 5'd1, 5'd0, 5'd4, 32'h100, 32'd0, 32'h8, 5'd0, 4'b0011, 1, 1, 1, 0, 1);
        step();
        applyStimulus(1, 5'd4, 5'd5, 5'd6, 32'h0, 32'h2, 32'd0, 5'd0, 4'b0011, 0, 1, 0, 0, 0);
        #1;
        checkOutput("lu_stall", {31'd0, stall}, 32'd1);
        step();
        #1;
        checkOutput("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
        checkOutput("lu_bubble_stall", {31'd0, stall}, 32'd0);
        step();
        applyForward(0, 0, 0, 1, 5'd4, 32'hCAFE);
        #1;
        checkOutput("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("lu_add_dest", {27'd0, ex_dest}, 32'd6);
        checkOutput("lu_add_fwd", alu_a, 32'hCAFE);

        // Flush together with a load-use stall
        applyForward(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 5'd1, 5'd0, 5'd4, 32'h100, 32'd0, 32'h8, 5'd0, 4'b0011, 1, 1, 1, 0, 1);
        step();
        applyStimulus(1, 5'd4, 5'd5, 5'd6, 32'h0, 32'h2, 32'd0, 5'd0, 4'b0011, 0, 1, 0, 0, 0);
        flush = 1'b1;
        #1;
        checkOutput("fl_stall", {31'd0, stall}, 32'd1);
        step();
        flush = 1'b0;
        #1;
        checkOutput("fl_bubble", {31'd0, ex_valid}, 32'd0);
        step();
        #1;
        checkOutput("fl_then_add", {27'd0, ex_dest}, 32'd6);

        // Immediate select and shift amount
        applyStimulus(1, 5'd2, 5'd9, 5'd7, 32'h0, 32'h1, 32'h0000FFFF, 5'd4, 4'b0101, 1, 1, 0, 0, 0);
        step();
        applyForward(0, 0, 0, 1, 5'd9, 32'hDEAD);
        #1;
        checkOutput("imm_b", alu_b, 32'h0000FFFF);
        checkOutput("imm_store", ex_store_data, 32'hDEAD);
        checkOutput("imm_shamt", {27'd0, alu_shamt}, 32'd4);
        checkOutput("imm_op", {28'd0, alu_op}, 32'd5);

        // Reset arriving during a stall
        applyForward(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 5'd1, 5'd0, 5'd4, 32'h100, 32'd0, 32'h8, 5'd0, 4'b0011, 1, 1, 1, 0, 1);
        step();
        applyStimulus(1, 5'd4, 5'd5, 5'd6, 32'h0, 32'h2, 32'd0, 5'd0, 4'b0011, 0, 1, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checkOutput("rst_stall_drop", {31'd0, stall}, 32'd0);
        checkOutput("rst_stall_empty", {31'd0, ex_valid}, 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            applyStimulus(($urandom_range(0, 7) != 0),
                          5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                          $urandom, $urandom, $urandom, 5'($urandom), 4'($urandom_range(0, 7)),
                          1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
            applyForward(1'($urandom), 5'($urandom_range(0, 5)), $urandom,
                         1'($urandom), 5'($urandom_range(0, 5)), $urandom);
            step();
        end

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
